// File: rtl/dac_wave_player_pkg.sv
// Shared types and constants for the DAC playback path.
// Sample type, mid-scale code and the player FSM encoding live here so the
// ADC capture side can reuse the same definitions.
package dac_wave_player_pkg;

    typedef logic [13:0] dac_sample_t;

    // Offset-binary mid-scale: the DAC output sits at 0 V with this code.
    localparam dac_sample_t DAC_MIDSCALE = 14'h2000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } player_state_e;

    // A playback length is usable when it is 1..2**aw samples.
    function automatic logic len_ok(input logic [31:0] len, input int unsigned aw);
        return (len != 32'd0) && (len <= (32'd1 << aw));
    endfunction

endpackage

// File: rtl/wave_ram.sv
// Simple dual-port sample RAM, one write port and one registered read port.
// Read latency 1 cycle; a read and write of the same address in one cycle
// returns the old contents (read-first). No flow control.
module wave_ram #(
    parameter int AW = 11,
    parameter int DW = 14
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [2**AW];

    // Write and registered read share one process so read-first falls out of NBA ordering.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/dac_wave_player.sv
// Streams samples from an internal RAM to one DAC channel at rate_div+1 clocks per sample.
// Latency: start at edge T0 -> busy from T0+1 -> first sample with sample_stb at T0+2.
// No backpressure: the DAC consumes every sample; stop aborts, start while busy is ignored.
module dac_wave_player
    import dac_wave_player_pkg::*;
#(
    parameter int             AW       = 11,
    parameter int             DW       = 14,
    parameter int             DIV_W    = 16,
    parameter logic [DW-1:0]  MIDSCALE = DAC_MIDSCALE
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic             start,
    input  logic             stop,
    input  logic             loop_en,
    input  logic [AW:0]      length,
    input  logic [DIV_W-1:0] rate_div,
    input  logic [DW-1:0]    idle_value,
    output logic [DW-1:0]    dac_data,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic [15:0]      wrap_cnt
);

    localparam logic [AW:0]      ONE_L = 1;
    localparam logic [AW-1:0]    ONE_A = 1;
    localparam logic [DIV_W-1:0] ONE_D = 1;

    player_state_e    state, state_d;
    logic [AW:0]      len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt, cnt_d;
    logic [AW-1:0]    rd_addr, rd_addr_d;
    logic             last_q, last_d;         // sample on dac_data is the final one of the buffer
    logic             nxt_last_q, nxt_last_d; // sample waiting in ram_q is the final one
    logic [DW-1:0]    dac_d;
    logic             stb_d, busy_d, done_d, err_d;
    logic [15:0]      wrap_d;

    logic             ram_rd_en;
    logic [DW-1:0]    ram_q;
    logic [AW:0]      last_idx;
    logic             rd_is_last;
    logic [AW-1:0]    next_addr;

    // Address wraps modulo the latched length, not the RAM depth.
    assign last_idx   = len_q - ONE_L;
    assign rd_is_last = ({1'b0, rd_addr} == last_idx);
    assign next_addr  = rd_is_last ? '0 : rd_addr + ONE_A;

    wave_ram #(
        .AW (AW),
        .DW (DW)
    ) u_ram (
        .clk     (sys_clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // Next-state and output decode; the RAM is read one period ahead of each DAC load.
    always_comb begin
        state_d    = state;
        len_d      = len_q;
        div_d      = div_q;
        cnt_d      = cnt;
        rd_addr_d  = rd_addr;
        last_d     = last_q;
        nxt_last_d = nxt_last_q;
        dac_d      = dac_data;
        stb_d      = 1'b0;
        busy_d     = busy;
        done_d     = 1'b0;
        err_d      = err_len;
        wrap_d     = wrap_cnt;
        ram_rd_en  = 1'b0;

        case (state)
            IDLE: begin
                dac_d  = idle_value;
                busy_d = 1'b0;
                if (start && !stop) begin
                    if (len_ok(32'(length), AW)) begin
                        len_d     = length;
                        div_d     = rate_div;
                        rd_addr_d = '0;
                        wrap_d    = '0;
                        err_d     = 1'b0;
                        state_d   = PRIME;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            PRIME: begin
                ram_rd_en  = 1'b1;
                busy_d     = 1'b1;
                rd_addr_d  = next_addr;
                nxt_last_d = rd_is_last;
                last_d     = 1'b0;
                cnt_d      = '0;
                state_d    = PLAY;
            end
            PLAY: begin
                cnt_d = (cnt == div_q) ? '0 : cnt + ONE_D;
                if (cnt == '0) begin
                    if (last_q && !loop_en) begin
                        dac_d   = idle_value;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        dac_d      = ram_q;
                        stb_d      = 1'b1;
                        last_d     = nxt_last_q;
                        ram_rd_en  = 1'b1;
                        rd_addr_d  = next_addr;
                        nxt_last_d = rd_is_last;
                        if (last_q && (wrap_cnt != 16'hFFFF)) begin
                            wrap_d = wrap_cnt + 16'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort takes priority over everything else while playing.
        if (stop && (state != IDLE)) begin
            state_d   = IDLE;
            dac_d     = idle_value;
            busy_d    = 1'b0;
            stb_d     = 1'b0;
            done_d    = 1'b0;
            ram_rd_en = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            len_q      <= '0;
            div_q      <= '0;
            cnt        <= '0;
            rd_addr    <= '0;
            last_q     <= 1'b0;
            nxt_last_q <= 1'b0;
            dac_data   <= MIDSCALE;
            sample_stb <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            wrap_cnt   <= '0;
        end else begin
            state      <= state_d;
            len_q      <= len_d;
            div_q      <= div_d;
            cnt        <= cnt_d;
            rd_addr    <= rd_addr_d;
            last_q     <= last_d;
            nxt_last_q <= nxt_last_d;
            dac_data   <= dac_d;
            sample_stb <= stb_d;
            busy       <= busy_d;
            done       <= done_d;
            err_len    <= err_d;
            wrap_cnt   <= wrap_d;
        end
    end

endmodule

// File: tb/tb_dac_wave_player.sv
// Directed bench for dac_wave_player: one-shot, looped, full-depth, error,
// stop, reset and write-during-play scenarios with hand-computed expectations.
module tb_dac_wave_player;

    localparam logic [13:0] IDLE_V = 14'h0155;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [13:0] wr_data;
    logic        start;
    logic        stop;
    logic        loop_en;
    logic [11:0] length;
    logic [15:0] rate_div;
    logic [13:0] idle_value;
    logic [13:0] dac_data;
    logic        sample_stb;
    logic        busy;
    logic        done;
    logic        err_len;
    logic [15:0] wrap_cnt;

    logic [13:0] model [2048];
    int          checks   = 0;
    int          failures = 0;

    dac_wave_player dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .stop       (stop),
        .loop_en    (loop_en),
        .length     (length),
        .rate_div   (rate_div),
        .idle_value (idle_value),
        .dac_data   (dac_data),
        .sample_stb (sample_stb),
        .busy       (busy),
        .done       (done),
        .err_len    (err_len),
        .wrap_cnt   (wrap_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input logic [13:0] d);
        wr_en   = 1'b1;
        wr_addr = a[10:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        model[a[10:0]] = d;
    endtask

    // Leaves the bench just after edge T0 (start sampled).
    task automatic start_play(input int len, input int div, input logic lp);
        length   = len[11:0];
        rate_div = div[15:0];
        loop_en  = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_dac"},  32'(dac_data),   32'(IDLE_V));
        chk({tag, "_busy"}, 32'(busy),       32'd0);
        chk({tag, "_stb"},  32'(sample_stb), 32'd0);
        chk({tag, "_done"}, 32'(done),       32'd0);
    endtask

    initial begin
        int bad;
        logic [13:0] v;

        sys_rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; length = '0;
        rate_div = '0; idle_value = IDLE_V;

        // Reset state
        tick(); tick();
        chk("rst_dac",  32'(dac_data),   32'h2000);
        chk("rst_stb",  32'(sample_stb), 32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        chk("rst_done", 32'(done),       32'd0);
        chk("rst_err",  32'(err_len),    32'd0);
        chk("rst_wrap", 32'(wrap_cnt),   32'd0);
        sys_rst = 1'b0;
        tick();
        chk("idle_dac", 32'(dac_data), 32'(IDLE_V));

        // Fill the whole RAM, then the first four with 100..400
        for (int a = 0; a < 2048; a++) begin
            v = 14'(a * 7 + 3);
            wr(a, v);
        end
        wr(0, 14'd100); wr(1, 14'd200); wr(2, 14'd300); wr(3, 14'd400);

        // One-shot, rate_div=0
        start_play(4, 0, 1'b0);
        chk("t1_busy_T0", 32'(busy), 32'd0);
        tick();
        chk("t1_busy_T1", 32'(busy), 32'd1);
        chk("t1_stb_T1",  32'(sample_stb), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_dac",  32'(dac_data),   32'((k + 1) * 100));
            chk("t1_stb",  32'(sample_stb), 32'd1);
            chk("t1_busy", 32'(busy),       32'd1);
            chk("t1_done_early", 32'(done), 32'd0);
        end
        tick();
        chk("t1_end_dac",  32'(dac_data), 32'(IDLE_V));
        chk("t1_end_done", 32'(done),     32'd1);
        chk("t1_end_busy", 32'(busy),     32'd0);
        tick();
        chk("t1_done_pulse", 32'(done), 32'd0);

        // Loop, rate_div=2: three passes, loop_en cleared during the third
        start_play(4, 2, 1'b1);
        tick();
        for (int p = 0; p < 3; p++) begin
            for (int s = 0; s < 4; s++) begin
                if (p == 2 && s == 1) loop_en = 1'b0;
                for (int h = 0; h < 3; h++) begin
                    tick();
                    chk("t2_dac",  32'(dac_data),   32'((s + 1) * 100));
                    chk("t2_stb",  32'(sample_stb), (h == 0) ? 32'd1 : 32'd0);
                    chk("t2_wrap", 32'(wrap_cnt),   32'(p));
                    chk("t2_done", 32'(done),       32'd0);
                end
            end
        end
        tick();
        chk("t2_end_done", 32'(done),     32'd1);
        chk("t2_end_dac",  32'(dac_data), 32'(IDLE_V));
        chk("t2_end_busy", 32'(busy),     32'd0);

        // Full depth; a start pulse mid-play must be ignored
        start_play(2048, 0, 1'b0);
        tick();
        bad = 0;
        for (int i = 0; i < 2048; i++) begin
            if (i == 10) start = 1'b1;
            tick();
            start = 1'b0;
            if (dac_data !== model[i] || sample_stb !== 1'b1 || busy !== 1'b1 || done !== 1'b0)
                bad++;
        end
        chk("t3_stream_errors", 32'(bad), 32'd0);
        chk("t3_last_sample",   32'(dac_data), 32'(model[2047]));
        tick();
        chk("t3_end_done", 32'(done),     32'd1);
        chk("t3_end_dac",  32'(dac_data), 32'(IDLE_V));

        // Invalid lengths, then a valid start clears the flag
        start_play(0, 0, 1'b0);
        chk("t4_err_zero",  32'(err_len), 32'd1);
        tick();
        chk("t4_busy_zero", 32'(busy),    32'd0);
        start_play(2049, 0, 1'b0);
        tick();
        chk("t4_err_big",   32'(err_len), 32'd1);
        chk("t4_busy_big",  32'(busy),    32'd0);
        start_play(4, 0, 1'b0);
        chk("t4_err_clear", 32'(err_len), 32'd0);
        tick(); tick(); tick();
        chk("t4_dac_200",   32'(dac_data), 32'd200);

        // stop+start together while playing: stop wins
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk_idle("t5_stopstart");
        tick();
        chk("t5_no_done", 32'(done), 32'd0);
        chk("t5_no_busy", 32'(busy), 32'd0);

        // stop+start together while idle: nothing starts
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        tick();
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // Write RAM[1] on the same edge it is read: old value now, new on next pass
        start_play(4, 0, 1'b1);
        tick();
        wr_en = 1'b1; wr_addr = 11'd1; wr_data = 14'd777;
        tick();
        wr_en = 1'b0; model[1] = 14'd777;
        chk("t6_dac0", 32'(dac_data), 32'd100);
        tick(); chk("t6_old",  32'(dac_data), 32'd200);
        tick(); chk("t6_dac2", 32'(dac_data), 32'd300);
        tick(); chk("t6_dac3", 32'(dac_data), 32'd400);
        tick(); chk("t6_wrap", 32'(dac_data), 32'd100);
        tick(); chk("t6_new",  32'(dac_data), 32'd777);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_idle("t6_stop");

        // Length 1 loop, then reset mid-play
        start_play(1, 0, 1'b1);
        tick();
        tick();
        chk("t7_dac",   32'(dac_data), 32'd100);
        chk("t7_wrap0", 32'(wrap_cnt), 32'd0);
        tick();
        chk("t7_wrap1", 32'(wrap_cnt), 32'd1);
        chk("t7_stb",   32'(sample_stb), 32'd1);
        tick();
        chk("t7_wrap2", 32'(wrap_cnt), 32'd2);
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        chk("t8_rst_dac",  32'(dac_data),   32'h2000);
        chk("t8_rst_busy", 32'(busy),       32'd0);
        chk("t8_rst_stb",  32'(sample_stb), 32'd0);
        chk("t8_rst_done", 32'(done),       32'd0);
        chk("t8_rst_wrap", 32'(wrap_cnt),   32'd0);
        tick();
        chk("t8_post_busy", 32'(busy), 32'd0);
        chk("t8_post_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
